// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit seven-segment scan driver.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}; anode codes are one-cold.
package seg7_pkg;

  // Segment patterns for the decimal digits, the dash and a fully dark digit.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Digit enables, [0]=ones .. [3]=unused leftmost digit.
  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_HUND = 4'b1011;
  localparam logic [3:0] AN_NONE = 4'b1111;

  // Scan slot currently being driven; the fourth slot stays dark so every
  // lit digit gets the same duty cycle as a full 4-digit display.
  typedef enum logic [1:0] {
    DIG_ONES = 2'd0,
    DIG_TENS = 2'd1,
    DIG_HUND = 2'd2,
    DIG_DARK = 2'd3
  } digit_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-BCD codes 10..15 show a dash; the decimal point is never lit.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  // Plain lookup of the segment pattern for one nibble.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/top_mod_seg7.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display
// showing a 3-digit BCD value. One digit is lit per slot of DIV_COUNT clocks;
// the leftmost digit is unused but keeps its (dark) slot. Outputs are
// registered and active-low, lagging the scan index by one clock.
module top_mod_seg7
  import seg7_pkg::*;
#(
  parameter int DIV_COUNT = 50000,
  parameter bit BLANK_LZ  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundred,
  output logic [7:0] led,
  output logic [3:0] anode
);

  localparam int             CW       = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DIV_COUNT - 1);

  logic [CW-1:0] prescale;
  digit_t        digit;
  logic [3:0]    sel_bcd;
  logic [3:0]    sel_anode;
  logic          sel_blank;
  logic [7:0]    dec_seg;
  logic          blank_hund;
  logic          blank_tens;

  // Slot timer: count 0..DIV_COUNT-1, stepping to the next digit on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
      digit    <= DIG_ONES;
    end else if (prescale == CNT_LAST) begin
      prescale <= '0;
      digit    <= digit_t'(digit + 2'd1);
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  // Leading zeros: hundreds when zero, tens only when hundreds is also zero.
  assign blank_hund = BLANK_LZ && (hundred == 4'd0);
  assign blank_tens = BLANK_LZ && (hundred == 4'd0) && (tens == 4'd0);

  // Pick the digit value, its anode and whether it is blanked for this slot.
  always_comb begin
    sel_bcd   = ones;
    sel_anode = AN_NONE;
    sel_blank = 1'b1;
    case (digit)
      DIG_ONES: begin
        sel_bcd   = ones;
        sel_anode = AN_ONES;
        sel_blank = 1'b0;
      end
      DIG_TENS: begin
        sel_bcd   = tens;
        sel_anode = AN_TENS;
        sel_blank = blank_tens;
      end
      DIG_HUND: begin
        sel_bcd   = hundred;
        sel_anode = AN_HUND;
        sel_blank = blank_hund;
      end
      default: begin
        sel_bcd   = ones;
        sel_anode = AN_NONE;
        sel_blank = 1'b1;
      end
    endcase
  end

  // A single shared decoder is enough since only one digit is lit at a time.
  seg7_decode u_decode (
    .bcd (sel_bcd),
    .seg (dec_seg)
  );

  // Registered pin drivers; dark during reset so no segment glitches on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode <= AN_NONE;
      led   <= SEG_BLANK;
    end else begin
      anode <= sel_anode;
      led   <= sel_blank ? SEG_BLANK : dec_seg;
    end
  end

endmodule

// File: tb/tb_top_mod_seg7.sv
// Bench for top_mod_seg7 with DIV_COUNT=4: one instance without and one with
// leading-zero blanking, a cycle-count based reference model compared every
// cycle, and directed checks against hand-computed literals.
module tb_top_mod_seg7;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ones = 4'd4;
  logic [3:0] tens = 4'd7;
  logic [3:0] hundred = 4'd6;
  logic [7:0] led, led_lz;
  logic [3:0] anode, anode_lz;

  int total = 0;
  int bad = 0;

  always #20 clk = ~clk;

  top_mod_seg7 #(.DIV_COUNT(D), .BLANK_LZ(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .ones(ones), .tens(tens), .hundred(hundred),
    .led(led), .anode(anode)
  );

  top_mod_seg7 #(.DIV_COUNT(D), .BLANK_LZ(1'b1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .ones(ones), .tens(tens), .hundred(hundred),
    .led(led_lz), .anode(anode_lz)
  );

  // Segment table straight from the decode rules, indexed by digit value.
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82,
                               8'hF8, 8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF,
                               8'hBF, 8'hBF};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Edge n after reset release (n=1,2,..) shows slot ((n-1)/D) mod 4.
  int         edges;
  logic [3:0] m_an;
  logic [7:0] m_led, m_led_lz;

  function automatic logic [3:0] an_of(input int slot);
    if (slot == 3) return 4'b1111;
    return ~(4'b0001 << slot);
  endfunction

  function automatic logic [7:0] led_of(input int slot, input bit lz);
    int v;
    if (slot == 3) return 8'hFF;
    v = (slot == 0) ? int'(ones) : (slot == 1) ? int'(tens) : int'(hundred);
    if (lz && slot == 2 && hundred == 0) return 8'hFF;
    if (lz && slot == 1 && hundred == 0 && tens == 0) return 8'hFF;
    return seg_tab[v];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges    <= 0;
      m_an     <= 4'b1111;
      m_led    <= 8'hFF;
      m_led_lz <= 8'hFF;
    end else begin
      edges    <= edges + 1;
      m_an     <= an_of((edges / D) % 4);
      m_led    <= led_of((edges / D) % 4, 1'b0);
      m_led_lz <= led_of((edges / D) % 4, 1'b1);
    end
  end

  // Every-cycle comparison against the model, plus the one-cold anode rule.
  always @(negedge clk) begin
    check("model_anode", {4'h0, anode}, {4'h0, m_an});
    check("model_led", led, m_led);
    check("model_anode_lz", {4'h0, anode_lz}, {4'h0, m_an});
    check("model_led_lz", led_lz, m_led_lz);
    check("one_cold", 8'($countones(~anode) <= 1), 8'd1);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until the given instance shows the target anode, bounded.
  task automatic wait_anode(input logic [3:0] target, input bit use_lz, input string name);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if ((use_lz ? anode_lz : anode) == target) found = 1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s: anode %b never seen within 40 cycles", name, target);
    end
  endtask

  logic [3:0] frame_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
  logic [7:0] frame_led [4] = '{8'h99, 8'hF8, 8'h82, 8'hFF};

  initial begin
    // Reset held for 100 ns.
    #100;
    check("reset_anode", {4'h0, anode}, 8'h0F);
    check("reset_led", led, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;

    // Two full frames of 674, cycle by cycle.
    for (int i = 0; i < 32; i++) begin
      step();
      check("scan_anode", {4'h0, anode}, {4'h0, frame_an[(i / D) % 4]});
      check("scan_led", led, frame_led[(i / D) % 4]);
    end

    // Decoder sweep on the ones digit, loaded during the dark slot.
    for (int v = 0; v < 16; v++) begin
      wait_anode(4'b1111, 1'b0, "sweep_dark");
      ones = 4'(v);
      wait_anode(4'b1110, 1'b0, "sweep_ones");
      check("sweep_led", led, seg_tab[v]);
    end

    // Leading-zero blanking on the BLANK_LZ instance: value 005.
    wait_anode(4'b1111, 1'b1, "lz_dark");
    hundred = 4'd0; tens = 4'd0; ones = 4'd5;
    wait_anode(4'b1110, 1'b1, "lz_ones");
    check("lz_ones_led", led_lz, 8'h92);
    wait_anode(4'b1101, 1'b1, "lz_tens");
    check("lz_tens_led", led_lz, 8'hFF);
    check("nolz_tens_led", led, 8'hC0);
    wait_anode(4'b1011, 1'b1, "lz_hund");
    check("lz_hund_led", led_lz, 8'hFF);
    check("nolz_hund_led", led, 8'hC0);

    // Value 035: tens now shown, hundreds still blank.
    wait_anode(4'b1111, 1'b1, "lz2_dark");
    tens = 4'd3;
    wait_anode(4'b1101, 1'b1, "lz2_tens");
    check("lz2_tens_led", led_lz, 8'hB0);
    wait_anode(4'b1011, 1'b1, "lz2_hund");
    check("lz2_hund_led", led_lz, 8'hFF);

    // Ones changed while the tens digit is being shown.
    hundred = 4'd6; tens = 4'd7; ones = 4'd4;
    wait_anode(4'b1110, 1'b0, "mid_ones0");
    check("mid_before_led", led, 8'h99);
    wait_anode(4'b1101, 1'b0, "mid_tens");
    ones = 4'd9;
    wait_anode(4'b1110, 1'b0, "mid_ones1");
    check("mid_after_led", led, 8'h90);

    // Reset asserted mid-slot goes dark with no clock edge.
    step();
    step();
    #5;
    rst_n = 1'b0;
    #1;
    check("async_rst_anode", {4'h0, anode}, 8'h0F);
    check("async_rst_led", led, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("restart_anode", {4'h0, anode}, 8'h0E);
    check("restart_led", led, 8'h90);
    for (int i = 0; i < 20; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
